// File: rtl/pll_dri_pkg.sv
// Shared definitions for the PLL DRI register-access master.
// Holds the FSM state encoding, response error codes, DRI_CTRL field
// positions and the DRI_RDATA done-flag position.
package pll_dri_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACCESS   = 3'd1,
    ST_RELEASE  = 3'd2,
    ST_LOCKWAIT = 3'd3,
    ST_RESP     = 3'd4
  } state_e;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_DRI_TO  = 2'b01;
  localparam logic [1:0] ERR_LOCK_TO = 2'b10;

  localparam int unsigned CTRL_STROBE = 10;
  localparam int unsigned CTRL_WRITE  = 9;
  localparam int unsigned DONE_BIT    = 32;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  // Saturating increment for the handshake/lock counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/pll_dri_sync2.sv
// Two-flop synchroniser for a single asynchronous level (PLL_LOCK).
// Ports: clk, rst_n (async active-low), async_i (raw level),
//        sync_o (level synchronised to clk, 2-cycle latency).
module pll_dri_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = async_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/pll_dri_master.sv
// PLL Dynamic Reconfiguration Interface initiator.
// Converts single host read/write requests into four-phase DRI transactions
// (strobe up, wait done, strobe down, wait done low) with timeouts, and can
// optionally wait for the PLL to relock after a write.
// Ports:
//   DRI_CLK / DRI_ARST_N            clock and async active-low reset
//   REQ_*                           host request channel (ready only in IDLE)
//   RSP_*                           host response channel (held until RSP_READY)
//   DRI_CTRL / DRI_WDATA / DRI_RDATA  PLL DRI port
//   PLL_LOCK                        asynchronous PLL lock indicator
module pll_dri_master
  import pll_dri_pkg::*;
#(
  parameter int unsigned ADDR_W       = 9,
  parameter int unsigned DRI_TIMEOUT  = 255,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic                DRI_CLK,
  input  logic                DRI_ARST_N,
  input  logic                REQ_VALID,
  output logic                REQ_READY,
  input  logic                REQ_WRITE,
  input  logic [ADDR_W-1:0]   REQ_ADDR,
  input  logic [DATA_W-1:0]   REQ_WDATA,
  input  logic                REQ_RELOCK,
  output logic                RSP_VALID,
  input  logic                RSP_READY,
  output logic [DATA_W-1:0]   RSP_RDATA,
  output logic [1:0]          RSP_ERR,
  output logic [ADDR_W+1:0]   DRI_CTRL,
  output logic [DATA_W:0]     DRI_WDATA,
  input  logic [DATA_W:0]     DRI_RDATA,
  input  logic                PLL_LOCK
);

  localparam int unsigned CTRL_W = ADDR_W + 2;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [1:0]          err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [DATA_W:0]     wdata_q, wdata_d;
  logic                relock_q, relock_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   dri_rd_q, dri_rd_d;
  logic                seen_low_q, seen_low_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                lock_s;

  pll_dri_sync2 u_lock_sync (
    .clk     (DRI_CLK),
    .rst_n   (DRI_ARST_N),
    .async_i (PLL_LOCK),
    .sync_o  (lock_s)
  );

  // Done flag and read data are registered together so the captured data
  // always belongs to the cycle in which done was seen.
  always_comb begin
    done_d   = DRI_RDATA[DONE_BIT];
    dri_rd_d = DRI_RDATA[DATA_W-1:0];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    ctrl_d     = ctrl_q;
    wdata_d    = wdata_q;
    relock_d   = relock_q;
    seen_low_d = seen_low_q;
    cnt_inc    = sat_inc(cnt_q);

    unique case (state_q)
      ST_IDLE: begin
        if (REQ_VALID && req_ready_q) begin
          state_d  = ST_ACCESS;
          cnt_d    = '0;
          err_d    = ERR_OK;
          rdata_d  = '0;
          ctrl_d   = {1'b1, REQ_WRITE, REQ_ADDR};
          wdata_d  = {1'b0, REQ_WDATA};
          relock_d = REQ_RELOCK;
        end
      end

      ST_ACCESS: begin
        cnt_d = cnt_inc;
        if (done_q) begin
          if (!ctrl_q[CTRL_WRITE]) begin
            rdata_d = dri_rd_q;
          end
          ctrl_d[CTRL_STROBE] = 1'b0;
          cnt_d               = '0;
          state_d             = ST_RELEASE;
        end else if (cnt_inc >= CNT_W'(DRI_TIMEOUT)) begin
          err_d               = ERR_DRI_TO;
          ctrl_d[CTRL_STROBE] = 1'b0;
          cnt_d               = '0;
          state_d             = ST_RELEASE;
        end
      end

      // Write/address stay on the bus until the responder drops done.
      ST_RELEASE: begin
        cnt_d = cnt_inc;
        if (!done_q) begin
          cnt_d      = '0;
          seen_low_d = 1'b0;
          ctrl_d     = '0;
          wdata_d    = '0;
          if (ctrl_q[CTRL_WRITE] && relock_q && (err_q == ERR_OK)) begin
            state_d = ST_LOCKWAIT;
          end else begin
            state_d = ST_RESP;
          end
        end else if (cnt_inc >= CNT_W'(DRI_TIMEOUT)) begin
          err_d   = ERR_DRI_TO;
          cnt_d   = '0;
          ctrl_d  = '0;
          wdata_d = '0;
          state_d = ST_RESP;
        end
      end

      // Only a low-then-high lock sequence counts as a relock.
      ST_LOCKWAIT: begin
        cnt_d = cnt_inc;
        if (!lock_s) begin
          seen_low_d = 1'b1;
        end
        if (seen_low_q && lock_s) begin
          err_d   = ERR_OK;
          cnt_d   = '0;
          state_d = ST_RESP;
        end else if (cnt_inc >= CNT_W'(LOCK_TIMEOUT)) begin
          err_d   = ERR_LOCK_TO;
          cnt_d   = '0;
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        if (RSP_READY) begin
          err_d   = ERR_OK;
          rdata_d = '0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge DRI_CLK or negedge DRI_ARST_N) begin
    if (!DRI_ARST_N) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      err_q       <= ERR_OK;
      rdata_q     <= '0;
      ctrl_q      <= '0;
      wdata_q     <= '0;
      relock_q    <= 1'b0;
      done_q      <= 1'b0;
      dri_rd_q    <= '0;
      seen_low_q  <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      ctrl_q      <= ctrl_d;
      wdata_q     <= wdata_d;
      relock_q    <= relock_d;
      done_q      <= done_d;
      dri_rd_q    <= dri_rd_d;
      seen_low_q  <= seen_low_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign REQ_READY = req_ready_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_RDATA = rdata_q;
  assign RSP_ERR   = err_q;
  assign DRI_CTRL  = ctrl_q;
  assign DRI_WDATA = wdata_q;

endmodule

// File: tb/tb_pll_dri_master.sv
// Self-checking bench for pll_dri_master: table-driven DRI accesses plus
// hand-written sequences for timeout, relock, lock timeout and reset.
module tb_pll_dri_master;
  import pll_dri_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [8:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_relock = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [10:0] dri_ctrl;
  logic [32:0] dri_wdata;
  logic        dri_done = 1'b0;
  logic [31:0] dri_data = '0;
  logic        pll_lock = 1'b1;

  logic        resp_hang = 1'b0;
  logic [31:0] resp_data = '0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] rd;
    logic [1:0]  err;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic        w;
    logic [8:0]  a;
    logic [31:0] d;
    logic [31:0] rsp;
    logic [10:0] ctrl;
    logic [32:0] wd;
    logic [31:0] rd;
  } vec_t;
  vec_t vecs[5];

  int          strobe_total = 0;
  logic [10:0] last_ctrl = '0;
  logic [32:0] last_wdata = '0;

  pll_dri_master dut (
    .DRI_CLK    (clk),
    .DRI_ARST_N (rst_n),
    .REQ_VALID  (req_valid),
    .REQ_READY  (req_ready),
    .REQ_WRITE  (req_write),
    .REQ_ADDR   (req_addr),
    .REQ_WDATA  (req_wdata),
    .REQ_RELOCK (req_relock),
    .RSP_VALID  (rsp_valid),
    .RSP_READY  (rsp_ready),
    .RSP_RDATA  (rsp_rdata),
    .RSP_ERR    (rsp_err),
    .DRI_CTRL   (dri_ctrl),
    .DRI_WDATA  (dri_wdata),
    .DRI_RDATA  ({dri_done, dri_data}),
    .PLL_LOCK   (pll_lock)
  );

  always #5 clk = ~clk;

  // DRI responder: done follows the strobe one cycle later unless hung.
  always @(posedge clk) begin
    dri_done <= resp_hang ? 1'b0 : dri_ctrl[10];
    dri_data <= resp_data;
  end

  // Bus monitor: counts strobe-high cycles and keeps the last strobed payload.
  always @(negedge clk) begin
    if (dri_ctrl[10]) begin
      strobe_total = strobe_total + 1;
      last_ctrl    = dri_ctrl;
      last_wdata   = dri_wdata;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_req(input logic w, input logic [8:0] a, input logic [31:0] d,
                        input logic rl, input logic [31:0] exp_rd, input logic [1:0] exp_err,
                        input bit expect_rsp);
    int n = 0;
    if (expect_rsp) sb_q.push_back('{rd: exp_rd, err: exp_err});
    @(negedge clk);
    while (!req_ready) begin
      n++;
      if (n > 1000) begin
        check("req_ready_wait", 64'(req_ready), 64'd1);
        return;
      end
      @(negedge clk);
    end
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_relock = rl;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Waits for a response, optionally holds RSP_READY low for 'hold' cycles,
  // compares against the scoreboard and completes the handshake. With
  // 'chain' a new read is presented during the handshake cycle.
  task automatic wait_rsp(input int bound, input int hold, input bit chain,
                          input logic [8:0] caddr, output int cyc);
    exp_t e;
    logic [31:0] r0;
    logic [1:0]  e0;
    int unstable;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (rsp_valid) break;
      cyc++;
      if (cyc > bound) begin
        check("rsp_wait", 64'(rsp_valid), 64'd1);
        return;
      end
    end
    check("req_ready_in_resp", 64'(req_ready), 64'd0);
    r0 = rsp_rdata; e0 = rsp_err; unstable = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== r0 || rsp_err !== e0) unstable++;
    end
    if (hold > 0) check("rsp_hold_stable", 64'(unstable), 64'd0);
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL sb_underflow: got response rdata 0x%0h err %0d with none expected", rsp_rdata, rsp_err);
    end else begin
      e = sb_q.pop_front();
      check("rsp_rdata", 64'(rsp_rdata), 64'(e.rd));
      check("rsp_err", 64'(rsp_err), 64'(e.err));
    end
    rsp_ready = 1'b1;
    if (chain) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = caddr; req_wdata = '0; req_relock = 1'b0;
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_after_hs", 64'(rsp_valid), 64'd0);
    check("req_ready_after_hs", 64'(req_ready), 64'd1);
    if (chain) begin
      check("no_accept_in_hs", 64'(dri_ctrl[10]), 64'd0);
      @(posedge clk);
      #1 req_valid = 1'b0;
    end
  endtask

  initial begin
    int cyc;
    int st0;
    int early;
    int n;

    vecs[0] = '{1'b0, 9'h010, 32'h0000_0000, 32'h0000_1234, 11'h410, 33'h0_0000_0000, 32'h0000_1234};
    vecs[1] = '{1'b1, 9'h005, 32'h0000_0019, 32'hCAFE_0000, 11'h605, 33'h0_0000_0019, 32'h0000_0000};
    vecs[2] = '{1'b0, 9'h1FF, 32'hA5A5_0000, 32'hDEAD_BEEF, 11'h5FF, 33'h0_A5A5_0000, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 9'h100, 32'hFFFF_FFFF, 32'h0000_0001, 11'h700, 33'h0_FFFF_FFFF, 32'h0000_0000};
    vecs[4] = '{1'b0, 9'h000, 32'h0000_0000, 32'h8000_0001, 11'h400, 33'h0_0000_0000, 32'h8000_0001};

    // Reset values
    #12;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_dri_ctrl", 64'(dri_ctrl), 64'd0);
    check("rst_dri_wdata", 64'(dri_wdata), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven accesses with a 1-cycle responder
    for (int i = 0; i < 5; i++) begin
      resp_data = vecs[i].rsp;
      do_req(vecs[i].w, vecs[i].a, vecs[i].d, 1'b0, vecs[i].rd, ERR_OK, 1'b1);
      wait_rsp(50, 0, 1'b0, 9'h0, cyc);
      check($sformatf("vec%0d_ctrl", i), 64'(last_ctrl), 64'(vecs[i].ctrl));
      check($sformatf("vec%0d_wdata", i), 64'(last_wdata), 64'(vecs[i].wd));
      check($sformatf("vec%0d_latency", i), 64'(cyc), 64'd6);
    end

    // Response held for 10 cycles, then a read presented during the handshake
    resp_data = 32'h0000_0011;
    do_req(1'b0, 9'h044, 32'h0, 1'b0, 32'h0000_0011, ERR_OK, 1'b1);
    sb_q.push_back('{rd: 32'h0000_0011, err: ERR_OK});
    wait_rsp(50, 10, 1'b1, 9'h033, cyc);
    @(negedge clk);
    check("chain_ctrl", 64'(dri_ctrl), 64'h433);
    wait_rsp(50, 0, 1'b0, 9'h0, cyc);

    // DRI timeout, then a good read
    resp_hang = 1'b1;
    st0 = strobe_total;
    do_req(1'b0, 9'h022, 32'h0, 1'b0, 32'h0, ERR_DRI_TO, 1'b1);
    wait_rsp(400, 0, 1'b0, 9'h0, cyc);
    check("to_strobe_cycles", 64'(strobe_total - st0), 64'd255);
    check("to_latency", 64'(cyc), 64'd256);
    resp_hang = 1'b0;
    resp_data = 32'h0000_1234;
    do_req(1'b0, 9'h010, 32'h0, 1'b0, 32'h0000_1234, ERR_OK, 1'b1);
    wait_rsp(50, 0, 1'b0, 9'h0, cyc);

    // Relock write: lock drops 3 cycles after release, returns 100 later
    resp_data = '0;
    do_req(1'b1, 9'h0C8, 32'h0000_0042, 1'b1, 32'h0, ERR_OK, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dri_ctrl[10] && n < 50);
    check("relock_strobe_drop", 64'(dri_ctrl[10]), 64'd0);
    early = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) early++;
    end
    pll_lock = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (rsp_valid) early++;
    end
    pll_lock = 1'b1;
    wait_rsp(200, 0, 1'b0, 9'h0, cyc);
    check("relock_no_early_rsp", 64'(early), 64'd0);
    check("relock_latency_window", 64'((103 + cyc >= 104) && (103 + cyc <= 108)), 64'd1);

    // Relock write with lock never returning (already high, never drops)
    do_req(1'b1, 9'h0C9, 32'h0000_0007, 1'b1, 32'h0, ERR_LOCK_TO, 1'b1);
    wait_rsp(70000, 0, 1'b0, 9'h0, cyc);
    check("lock_to_latency", 64'(cyc), 64'd65541);

    // Reset in the middle of an access
    resp_hang = 1'b1;
    do_req(1'b0, 9'h077, 32'h0, 1'b0, 32'h0, ERR_OK, 1'b0);
    repeat (5) @(negedge clk);
    check("mid_strobe_before_rst", 64'(dri_ctrl[10]), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("mid_rst_ctrl_async", 64'(dri_ctrl), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    resp_hang = 1'b0;
    @(negedge clk);
    check("mid_rst_req_ready", 64'(req_ready), 64'd1);
    early = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) early++;
    end
    check("mid_rst_no_rsp", 64'(early), 64'd0);
    check("sb_empty_end", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
